// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_pkg
//  Description : Shared pipeline definitions: datapath widths, fetch FSM
//                state encodings and the PC increment.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

   localparam int ALU_WIDTH       = 4;
   localparam int OPCODE_WIDTH    = 7;
   localparam int EXCEPTION_WIDTH = 4;

   // Byte distance between consecutive RV32I instructions
   localparam int PC_INCR = 4;

   // Fetch FSM states
   typedef enum logic [1:0] {
      FS_WAIT    = 2'd0,   // request outstanding for r_pc
      FS_HOLD    = 2'd1,   // skid buffer full, no request
      FS_DISCARD = 2'd2    // stale request in flight, its data is dropped
   } fs_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_skid_buffer
//  Description : One-entry {valid, instr, pc} holding register that catches a
//                returning instruction while decode is stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_buffer
   import fetch_stage_pkg::*;
#(
   parameter int PC_WIDTH = 32,
   parameter int IWIDTH   = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_load,
   input  logic                i_unload,
   input  logic                i_clear,
   input  logic [IWIDTH-1:0]   i_instr,
   input  logic [PC_WIDTH-1:0] i_pc,
   output logic                o_valid,
   output logic [IWIDTH-1:0]   o_instr,
   output logic [PC_WIDTH-1:0] o_pc
);

   // Clear wins over load so a redirect always empties the entry
   always_ff @(posedge clk) begin
      if (rst) begin
         o_valid <= 1'b0;
         o_instr <= '0;
         o_pc    <= '0;
      end else if (i_clear) begin
         o_valid <= 1'b0;
      end else if (i_load) begin
         o_valid <= 1'b1;
         o_instr <= i_instr;
         o_pc    <= i_pc;
      end else if (i_unload) begin
         o_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : RV32I instruction fetch stage. Holds the PC, issues one
//                outstanding req/ack read at a time, buffers one returning
//                instruction under decode stall and drops in-flight fetches
//                on a PC redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int                   PC_WIDTH = 32,
   parameter int                   IWIDTH   = 32,
   parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
   input  logic                fs_clk,
   input  logic                fs_rst,
   output logic [PC_WIDTH-1:0] fs_o_imem_addr,
   output logic                fs_o_imem_req,
   input  logic                fs_i_imem_ack,
   input  logic [IWIDTH-1:0]   fs_i_imem_instr,
   output logic [IWIDTH-1:0]   fs_o_instr,
   output logic [PC_WIDTH-1:0] fs_o_pc,
   output logic                fs_o_ce,
   output logic                fs_o_flush,
   input  logic                fs_i_stall,
   input  logic                fs_i_change_pc,
   input  logic [PC_WIDTH-1:0] fs_i_new_pc
);

   fs_state_t             r_state, w_state_next;
   logic [PC_WIDTH-1:0]   r_pc, w_pc_next;
   logic [PC_WIDTH-1:0]   r_stale_pc, w_stale_pc_next;
   logic [IWIDTH-1:0]     r_out_instr, w_out_instr_next;
   logic [PC_WIDTH-1:0]   r_out_pc, w_out_pc_next;
   logic                  r_out_ce, w_out_ce_next;
   logic                  r_out_flush, w_out_flush_next;

   logic                  w_buf_load, w_buf_unload, w_buf_clear;
   logic                  w_buf_valid;
   logic [IWIDTH-1:0]     w_buf_instr;
   logic [PC_WIDTH-1:0]   w_buf_pc;
   logic [PC_WIDTH-1:0]   w_new_pc_aligned;

   // Redirect targets are word aligned
   assign w_new_pc_aligned = fs_i_new_pc & ~PC_WIDTH'(3);

   // Memory side is a pure function of registered state: no input-to-output path.
   // DISCARD keeps presenting the address of the request still in flight.
   assign fs_o_imem_req  = (r_state != FS_HOLD);
   assign fs_o_imem_addr = (r_state == FS_DISCARD) ? r_stale_pc : r_pc;

   assign fs_o_instr = r_out_instr;
   assign fs_o_pc    = r_out_pc;
   assign fs_o_ce    = r_out_ce;
   assign fs_o_flush = r_out_flush;

   fetch_skid_buffer #(
      .PC_WIDTH (PC_WIDTH),
      .IWIDTH   (IWIDTH)
   ) u_skid (
      .clk      (fs_clk),
      .rst      (fs_rst),
      .i_load   (w_buf_load),
      .i_unload (w_buf_unload),
      .i_clear  (w_buf_clear),
      .i_instr  (fs_i_imem_instr),
      .i_pc     (r_pc),
      .o_valid  (w_buf_valid),
      .o_instr  (w_buf_instr),
      .o_pc     (w_buf_pc)
   );

   // Next-state, PC and output-register decode; redirect outranks stall and ack
   always_comb begin
      w_state_next     = r_state;
      w_pc_next        = r_pc;
      w_stale_pc_next  = r_stale_pc;
      w_out_instr_next = r_out_instr;
      w_out_pc_next    = r_out_pc;
      w_out_ce_next    = r_out_ce;
      w_out_flush_next = 1'b0;
      w_buf_load       = 1'b0;
      w_buf_unload     = 1'b0;
      w_buf_clear      = 1'b0;

      if (fs_i_change_pc) begin
         w_pc_next        = w_new_pc_aligned;
         w_buf_clear      = 1'b1;
         w_out_ce_next    = 1'b0;
         w_out_flush_next = 1'b1;
         case (r_state)
            FS_WAIT: begin
               // An unacked request must still complete; remember its address
               if (!fs_i_imem_ack) begin
                  w_state_next    = FS_DISCARD;
                  w_stale_pc_next = r_pc;
               end
            end
            FS_HOLD:    w_state_next = FS_WAIT;
            FS_DISCARD: if (fs_i_imem_ack) w_state_next = FS_WAIT;
            default:    w_state_next = FS_WAIT;
         endcase
      end else begin
         case (r_state)
            FS_WAIT: begin
               if (fs_i_imem_ack) begin
                  w_pc_next = r_pc + PC_WIDTH'(PC_INCR);
                  if (!fs_i_stall) begin
                     w_out_instr_next = fs_i_imem_instr;
                     w_out_pc_next    = r_pc;
                     w_out_ce_next    = 1'b1;
                  end else begin
                     w_buf_load   = 1'b1;
                     w_state_next = FS_HOLD;
                  end
               end else if (!fs_i_stall) begin
                  w_out_ce_next = 1'b0;
               end
            end
            FS_HOLD: begin
               if (!fs_i_stall && w_buf_valid) begin
                  w_out_instr_next = w_buf_instr;
                  w_out_pc_next    = w_buf_pc;
                  w_out_ce_next    = 1'b1;
                  w_buf_unload     = 1'b1;
                  w_state_next     = FS_WAIT;
               end
            end
            FS_DISCARD: if (fs_i_imem_ack) w_state_next = FS_WAIT;
            default:    w_state_next = FS_WAIT;
         endcase
      end
   end

   // State, PC and output registers; reset abandons any request in flight
   always_ff @(posedge fs_clk) begin
      if (fs_rst) begin
         r_state     <= FS_WAIT;
         r_pc        <= RESET_PC;
         r_stale_pc  <= '0;
         r_out_instr <= '0;
         r_out_pc    <= '0;
         r_out_ce    <= 1'b0;
         r_out_flush <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_pc        <= w_pc_next;
         r_stale_pc  <= w_stale_pc_next;
         r_out_instr <= w_out_instr_next;
         r_out_pc    <= w_out_pc_next;
         r_out_ce    <= w_out_ce_next;
         r_out_flush <= w_out_flush_next;
      end
   end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the 5-stage RV32I pipeline; the producer end of the fetch→decode interface that `decoder_stage` consumes (`instr`, `pc`, `ce`, `stall`, `flush`). It holds the program counter and issues one-outstanding req/ack reads to instruction memory. It catches a returning instruction in a one-entry skid buffer when decode stalls, and discards in-flight fetches on a PC redirect.

## Interface
- `PC_WIDTH`, default 32: program counter / instruction memory address width.
- `IWIDTH`, default 32: instruction width.
- `RESET_PC`, default 0: first fetch address after reset.

Ports:
- `fs_clk` in 1: clock; all state updates on the rising edge.
- `fs_rst` in 1: reset, synchronous, active-high.
- `fs_o_imem_addr` out `PC_WIDTH`: fetch address; held stable while `fs_o_imem_req`=1.
- `fs_o_imem_req` out 1: read request.
- `fs_i_imem_ack` in 1: read done; may assert in the same cycle as req or later.
- `fs_i_imem_instr` in `IWIDTH`: read data; valid when ack=1.
- `fs_o_instr` out `IWIDTH`: instruction to decode (`ds_i_instr`).
- `fs_o_pc` out `PC_WIDTH`: address of `fs_o_instr` (`ds_i_pc`).
- `fs_o_ce` out 1: `fs_o_instr`/`fs_o_pc` valid (`ds_i_ce`).
- `fs_o_flush` out 1: one-cycle flush to decode (`ds_i_flush`).
- `fs_i_stall` in 1: decode cannot accept; hold outputs.
- `fs_i_change_pc` in 1: redirect (branch/jump/trap).
- `fs_i_new_pc` in `PC_WIDTH`: redirect target; bits [1:0] forced to 0.

## Operation
- Registers: `pc` (address of current or next request), state, skid buffer {valid, instr, pc}, and output registers.
- States:
  - **WAIT**: `req`=1, `addr`=`pc`.
  - **HOLD**: `req`=0. The buffer is full and no request is outstanding.
  - **DISCARD**: `req`=1 with the stale address. The returning data is dropped.
- WAIT, ack=1, no redirect:
  - Accept the data; `pc`<=`pc`+4 (wraps mod 2^`PC_WIDTH`).
  - Stall=0: the outputs load {data, old `pc`}, `ce`<=1, and the state stays WAIT.
  - Stall=1: the buffer loads {data, old `pc`} and the state goes to HOLD.
- WAIT, ack=0: `pc` unchanged. The outputs get a bubble (`ce`<=0) unless stall=1.
- HOLD with stall=0: the outputs load from the buffer, `ce`<=1, the buffer empties, and the state goes to WAIT.
- HOLD with stall=1: nothing changes.
- Stall=1 in any state: `fs_o_instr`, `fs_o_pc` and `fs_o_ce` hold their values.
- Redirect (`fs_i_change_pc`=1) has priority over stall and ack:
  - `pc`<=`new_pc`, buffer valid<=0, `fs_o_ce`<=0, `fs_o_flush`<=1 (one cycle).
  - From WAIT with ack=0: go to DISCARD, since the request is outstanding and must complete.
  - From WAIT with ack=1: the data is dropped and the state stays WAIT.
  - From HOLD: go to WAIT.
- DISCARD, ack=1: drop the data and go to WAIT (the new `pc` is fetched next cycle). A second redirect during DISCARD only updates `pc`.
- `fs_o_flush`<=0 in every cycle without a redirect.

## Timing
- Reset values: `fs_o_ce`=0, `fs_o_flush`=0, `fs_o_instr`=0, `fs_o_pc`=0, buffer empty, `pc`=`RESET_PC`, state WAIT.
  - `fs_o_imem_req`=1 with `addr`=`RESET_PC` in the first cycle after reset is released.
  - The memory is reset by the same `fs_rst`. An ack sampled while `fs_rst`=1 is ignored.
- Reset mid-operation abandons any outstanding request and clears the buffer and outputs.
- Latency: ack at edge N puts the instruction on `fs_o_*` after edge N (visible in cycle N+1).
- Throughput: with same-cycle ack, one instruction per cycle.
- Redirect at edge N:
  - The first fetch of `new_pc` is issued in cycle N+1 if there is no outstanding request.
  - Otherwise it is issued the cycle after the discarded ack.
- `fs_o_imem_req`/`addr` are decoded from state and `pc` only, with no input→output combinational path.
- At most one request is outstanding, and the buffer is never full while a request is outstanding.

## Structure
- State encodings (`FS_WAIT`, `FS_HOLD`, `FS_DISCARD`) and the `PC_INCR` constant (4) go in the shared define header alongside `ALU_WIDTH`/`OPCODE_WIDTH`/`EXCEPTION_WIDTH`.
- One sub-module, `fetch_skid_buffer`: a one-entry {valid, instr, pc} register with load, unload and clear inputs. The FSM, PC and output registers stay in `fetch_stage`.

## Test plan
- Zero-wait memory (ack=req, instr=addr|0x13), `RESET_PC`=0, no stall: after reset, `fs_o_pc` is 0,4,8,12 on consecutive cycles with `ce`=1 and `fs_o_instr`=0x13,0x17,…
- Two-cycle memory latency: `req` is held with a stable `addr`=4 until ack; `ce` pattern 1,0,1,0…
- Stall for 3 cycles when `fs_o_pc`=8: the outputs hold pc 8. Pc 12 goes to the buffer and `req`=0 during HOLD. After the stall is released, pc 12 and then 16 appear with no loss or duplication.
- Redirect to 0x100 while a pc-20 request is outstanding (ack 2 cycles later): `fs_o_flush`=1 for one cycle and `ce`=0. The pc-20 data never appears, and the next `fs_o_pc`=0x100.
- Redirect during stall with a full buffer: the buffered instruction is dropped and the outputs invalidate despite the stall. `new_pc`=0x203 is fetched as 0x200.
- Reset asserted mid-stream with `RESET_PC`=0x80: the outputs clear. The first post-reset request has `addr`=0x80, and the PC wraps 0xFFFFFFFC→0 on a redirect test.
